// File: rtl/dcs_host.sv
// Host-side sequencer for the DCS matrix accelerator: buffers one job, streams
// matrix and weights out, collects eight result words and drains them downstream.
`timescale 1ns/1ps

module dcs_host #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  input  logic [7:0]  job_data,
  output logic        job_ready,
  output logic        i_valid,
  output logic [7:0]  i_data,
  input  logic        w_ready,
  output logic        w_valid,
  output logic [7:0]  w_data,
  input  logic        o_valid,
  input  logic [31:0] o_data,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_last,
  input  logic        res_ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, LOAD, SEND_I, WAIT_W, SEND_W, COLLECT, DRAIN} state_t;

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [7:0]    r_buf [0:135];
  logic [31:0]   r_slot [0:7];
  state_t        r_state;
  logic [7:0]    r_idx;
  logic [TW-1:0] r_tmo;
  logic [2:0]    r_slotIdx;
  logic          r_jobReady, r_iValid, r_wValid, r_resValid, r_resLast, r_busy, r_err;
  logic [7:0]    r_iData, r_wData;
  logic [31:0]   r_resData;

  logic          w_bufWe;
  logic [7:0]    w_bufAddr;
  logic          w_slotWe;

  assign w_bufWe   = ((r_state == IDLE) || (r_state == LOAD)) && job_valid;
  assign w_bufAddr = (r_state == IDLE) ? 8'd0 : r_idx;
  assign w_slotWe  = (r_state == COLLECT) && o_valid;

  always_ff @(posedge clk) begin
    if (w_bufWe) r_buf[w_bufAddr] <= job_data;
  end

  always_ff @(posedge clk) begin
    if (w_slotWe) r_slot[r_slotIdx] <= o_data;
  end

  // r_tmo holds the 1-based index of the current idle cycle, so err lands on the TIMEOUT-th one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= 8'd0;
      r_tmo      <= '0;
      r_slotIdx  <= 3'd0;
      r_jobReady <= 1'b1;
      r_iValid   <= 1'b0;
      r_iData    <= 8'd0;
      r_wValid   <= 1'b0;
      r_wData    <= 8'd0;
      r_resValid <= 1'b0;
      r_resData  <= 32'd0;
      r_resLast  <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (job_valid) begin
            r_idx   <= 8'd1;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (job_valid) begin
            if (r_idx == 8'd135) begin
              r_jobReady <= 1'b0;
              r_iValid   <= 1'b1;
              r_iData    <= r_buf[0];
              r_idx      <= 8'd1;
              r_state    <= SEND_I;
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end
        end
        SEND_I: begin
          if (r_idx == 8'd128) begin
            r_iValid <= 1'b0;
            r_iData  <= 8'd0;
            r_tmo    <= TW'(1);
            r_state  <= WAIT_W;
          end else begin
            r_iData <= r_buf[r_idx];
            r_idx   <= r_idx + 8'd1;
          end
        end
        WAIT_W: begin
          if (w_ready) begin
            r_wValid <= 1'b1;
            r_wData  <= r_buf[128];
            r_idx    <= 8'd129;
            r_state  <= SEND_W;
          end else if (r_tmo == TMO_LAST) begin
            r_err      <= 1'b1;
            r_busy     <= 1'b0;
            r_jobReady <= 1'b1;
            r_tmo      <= '0;
            r_state    <= IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        SEND_W: begin
          if (r_idx == 8'd136) begin
            r_wValid  <= 1'b0;
            r_wData   <= 8'd0;
            r_tmo     <= TW'(1);
            r_slotIdx <= 3'd0;
            r_state   <= COLLECT;
          end else begin
            r_wData <= r_buf[r_idx];
            r_idx   <= r_idx + 8'd1;
          end
        end
        COLLECT: begin
          if (o_valid) begin
            r_tmo <= TW'(1);
            if (r_slotIdx == 3'd7) begin
              r_resValid <= 1'b1;
              r_resData  <= r_slot[0];
              r_resLast  <= 1'b0;
              r_slotIdx  <= 3'd0;
              r_state    <= DRAIN;
            end else begin
              r_slotIdx <= r_slotIdx + 3'd1;
            end
          end else if (r_tmo == TMO_LAST) begin
            r_err      <= 1'b1;
            r_busy     <= 1'b0;
            r_jobReady <= 1'b1;
            r_tmo      <= '0;
            r_slotIdx  <= 3'd0;
            r_state    <= IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        DRAIN: begin
          if (res_ready) begin
            if (r_slotIdx == 3'd7) begin
              r_resValid <= 1'b0;
              r_resData  <= 32'd0;
              r_resLast  <= 1'b0;
              r_slotIdx  <= 3'd0;
              r_busy     <= 1'b0;
              r_jobReady <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_resData <= r_slot[r_slotIdx + 3'd1];
              r_resLast <= (r_slotIdx == 3'd6);
              r_slotIdx <= r_slotIdx + 3'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign job_ready = r_jobReady;
  assign i_valid   = r_iValid;
  assign i_data    = r_iData;
  assign w_valid   = r_wValid;
  assign w_data    = r_wData;
  assign res_valid = r_resValid;
  assign res_data  = r_resData;
  assign res_last  = r_resLast;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule
